// File: rtl/periph_fll_bridge_if.sv
// Bus bundles for the FLL bridge: peripheral slave port and FLL master port.
// The bridge uses periph_if.slave and fll_if.master; the environment uses the opposite modports.
interface periph_if #(
    parameter int ID_WIDTH = 9
);
    logic                req_i;
    logic [31:0]         add_i;
    logic                wen_i;
    logic [31:0]         wdata_i;
    logic [3:0]          be_i;
    logic [ID_WIDTH-1:0] id_i;
    logic                gnt_o;
    logic                r_valid_o;
    logic                r_opc_o;
    logic [ID_WIDTH-1:0] r_id_o;
    logic [31:0]         r_rdata_o;

    modport master (
        output req_i, add_i, wen_i, wdata_i, be_i, id_i,
        input  gnt_o, r_valid_o, r_opc_o, r_id_o, r_rdata_o
    );
    modport slave (
        input  req_i, add_i, wen_i, wdata_i, be_i, id_i,
        output gnt_o, r_valid_o, r_opc_o, r_id_o, r_rdata_o
    );
endinterface

interface fll_if #(
    parameter int FLL_ADDR_WIDTH = 2,
    parameter int FLL_DATA_WIDTH = 32
);
    logic                      fll_req_o;
    logic                      fll_wrn_o;
    logic [FLL_ADDR_WIDTH-1:0] fll_add_o;
    logic [FLL_DATA_WIDTH-1:0] fll_data_o;
    logic                      fll_ack_i;
    logic [FLL_DATA_WIDTH-1:0] fll_r_data_i;
    logic                      fll_lock_i;
    logic                      lock_o;
    logic                      lock_lost_o;

    modport master (
        output fll_req_o, fll_wrn_o, fll_add_o, fll_data_o, lock_o, lock_lost_o,
        input  fll_ack_i, fll_r_data_i, fll_lock_i
    );
    modport slave (
        input  fll_req_o, fll_wrn_o, fll_add_o, fll_data_o, lock_o, lock_lost_o,
        output fll_ack_i, fll_r_data_i, fll_lock_i
    );
endinterface

// File: rtl/periph_fll_bridge.sv
// Peripheral-bus to FLL register bridge: one outstanding transaction, ack timeout, lock synchroniser.
// Latency: accept N -> fll_req N+1 -> response one cycle after ack; new requests stall (gnt=0) while busy.
module periph_fll_bridge #(
    parameter int ID_WIDTH       = 9,
    parameter int FLL_ADDR_WIDTH = 2,
    parameter int FLL_DATA_WIDTH = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic     clk_i,
    input  logic     rst_i,
    periph_if.slave  periph,
    fll_if.master    fll
);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t                    state, state_nxt;
    logic                      accept, ack_ok, tmo, partial_wr;
    logic [ID_WIDTH-1:0]       id_q;
    logic                      wen_q;
    logic [31:0]               wdata_q;
    logic [FLL_ADDR_WIDTH-1:0] add_q;
    logic                      opc_q;
    logic [31:0]               rdata_q;
    logic [15:0]               cnt_q;
    logic [1:0]                sync_q;
    logic                      lock_prev_q;
    logic                      unused_add;

    assign unused_add = ^{periph.add_i[31:FLL_ADDR_WIDTH+2], periph.add_i[1:0]};
    assign partial_wr = !periph.wen_i && (periph.be_i != 4'hF);

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        ack_ok    = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: if (periph.req_i) begin
                accept    = 1'b1;
                state_nxt = partial_wr ? RESP : REQ;
            end
            REQ: begin
                // ack wins over a timeout landing in the same cycle
                if (fll.fll_ack_i) begin
                    ack_ok    = 1'b1;
                    state_nxt = RESP;
                end else if (cnt_q == TMO_LAST) begin
                    tmo       = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_q        <= '0;
            wen_q       <= 1'b0;
            wdata_q     <= '0;
            add_q       <= '0;
            opc_q       <= 1'b0;
            rdata_q     <= '0;
            cnt_q       <= '0;
            sync_q      <= '0;
            lock_prev_q <= 1'b0;
        end else begin
            sync_q      <= {sync_q[0], fll.fll_lock_i};
            lock_prev_q <= sync_q[1];
            if (accept) begin
                id_q    <= periph.id_i;
                wen_q   <= periph.wen_i;
                wdata_q <= periph.wdata_i;
                add_q   <= periph.add_i[FLL_ADDR_WIDTH+1:2];
                opc_q   <= partial_wr;
                rdata_q <= '0;
                cnt_q   <= '0;
            end
            if (ack_ok) begin
                opc_q <= 1'b0;
                if (wen_q) rdata_q <= 32'(fll.fll_r_data_i);
            end else if (tmo) begin
                opc_q   <= 1'b1;
                rdata_q <= '0;
            end
            if (state == REQ && !fll.fll_ack_i) cnt_q <= cnt_q + 16'd1;
        end
    end

    // Everything is forced low while reset is held, even before the state register clears.
    always_comb begin
        periph.gnt_o     = 1'b0;
        periph.r_valid_o = 1'b0;
        periph.r_opc_o   = 1'b0;
        periph.r_id_o    = '0;
        periph.r_rdata_o = '0;
        fll.fll_req_o    = 1'b0;
        fll.fll_wrn_o    = 1'b0;
        fll.fll_add_o    = '0;
        fll.fll_data_o   = '0;
        fll.lock_o       = 1'b0;
        fll.lock_lost_o  = 1'b0;
        if (!rst_i) begin
            periph.gnt_o    = (state == IDLE) && periph.req_i;
            periph.r_id_o   = id_q;
            fll.lock_o      = sync_q[1];
            fll.lock_lost_o = lock_prev_q && !sync_q[1];
            if (state == REQ) begin
                fll.fll_req_o  = 1'b1;
                fll.fll_wrn_o  = wen_q;
                fll.fll_add_o  = add_q;
                fll.fll_data_o = FLL_DATA_WIDTH'(wdata_q);
            end
            if (state == RESP) begin
                periph.r_valid_o = 1'b1;
                periph.r_opc_o   = opc_q;
                periph.r_rdata_o = rdata_q;
            end
        end
    end
endmodule

// File: tb/tb_periph_fll_bridge.sv
// Directed bench for periph_fll_bridge; responses are checked against a queue of expected results.
module tb_periph_fll_bridge;
    localparam int IDW = 9;

    typedef struct packed {
        logic           opc;
        logic [IDW-1:0] id;
        logic [31:0]    rdata;
    } rsp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    rsp_t exp_q[$];
    rsp_t e;

    always #5 clk = ~clk;

    periph_if #(.ID_WIDTH(IDW)) pif();
    fll_if #(.FLL_ADDR_WIDTH(2), .FLL_DATA_WIDTH(32)) fif();

    periph_fll_bridge #(
        .ID_WIDTH(IDW), .FLL_ADDR_WIDTH(2), .FLL_DATA_WIDTH(32), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst),
        .periph (pif),
        .fll    (fif)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic nb();
        @(negedge clk);
    endtask

    task automatic issue(input logic wen, input logic [31:0] add, input logic [31:0] wdata,
                         input logic [3:0] be, input logic [IDW-1:0] id);
        pif.req_i   = 1'b1;
        pif.wen_i   = wen;
        pif.add_i   = add;
        pif.wdata_i = wdata;
        pif.be_i    = be;
        pif.id_i    = id;
    endtask

    // Response monitor
    always @(negedge clk) begin
        if (pif.r_valid_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got id 0x%0h with nothing pending", pif.r_id_o);
            end else begin
                e = exp_q.pop_front();
                chk1("rsp_opc", pif.r_opc_o, e.opc);
                chk("rsp_id", 32'(pif.r_id_o), 32'(e.id));
                chk("rsp_rdata", pif.r_rdata_o, e.rdata);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        pif.req_i = 1'b0; pif.wen_i = 1'b0; pif.add_i = '0; pif.wdata_i = '0;
        pif.be_i = '0; pif.id_i = '0;
        fif.fll_ack_i = 1'b0; fif.fll_r_data_i = '0; fif.fll_lock_i = 1'b0;

        // Reset with a request pending
        issue(1'b1, 32'h0, 32'h0, 4'hF, 9'd1);
        for (int i = 0; i < 2; i++) begin
            nb();
            chk1("rst_gnt", pif.gnt_o, 1'b0);
            chk1("rst_fll_req", fif.fll_req_o, 1'b0);
            chk1("rst_r_valid", pif.r_valid_o, 1'b0);
            chk1("rst_lock", fif.lock_o, 1'b0);
            cyc();
        end
        pif.req_i = 1'b0;
        rst = 1'b0;
        cyc();

        // Read, ack two cycles after fll_req rises
        issue(1'b1, 32'h8, 32'h0, 4'hF, 9'd3);
        exp_q.push_back(rsp_t'{1'b0, 9'd3, 32'hCAFE0001});
        nb(); chk1("rd_gnt", pif.gnt_o, 1'b1);
        cyc(); pif.req_i = 1'b0;
        nb(); chk1("rd_fll_req", fif.fll_req_o, 1'b1);
        chk("rd_fll_add", 32'(fif.fll_add_o), 32'd2);
        chk1("rd_fll_wrn", fif.fll_wrn_o, 1'b1);
        cyc();
        nb(); chk1("rd_fll_req_hold", fif.fll_req_o, 1'b1); chk1("rd_gnt_busy", pif.gnt_o, 1'b0);
        cyc(); fif.fll_ack_i = 1'b1; fif.fll_r_data_i = 32'hCAFE0001;
        cyc(); fif.fll_ack_i = 1'b0; fif.fll_r_data_i = '0;
        nb(); chk1("rd_r_valid", pif.r_valid_o, 1'b1);
        cyc();
        nb(); chk1("rd_r_valid_one", pif.r_valid_o, 1'b0);

        // Full write, ack on first REQ cycle
        issue(1'b0, 32'h4, 32'h12345678, 4'hF, 9'd5);
        exp_q.push_back(rsp_t'{1'b0, 9'd5, 32'h0});
        cyc(); pif.req_i = 1'b0; fif.fll_ack_i = 1'b1;
        nb(); chk1("wr_fll_req", fif.fll_req_o, 1'b1);
        chk("wr_fll_add", 32'(fif.fll_add_o), 32'd1);
        chk1("wr_fll_wrn", fif.fll_wrn_o, 1'b0);
        chk("wr_fll_data", fif.fll_data_o, 32'h12345678);
        cyc(); fif.fll_ack_i = 1'b0;
        nb(); chk1("wr_r_valid", pif.r_valid_o, 1'b1);
        cyc();

        // Partial write is rejected without an FLL access
        issue(1'b0, 32'h4, 32'hDEADBEEF, 4'h3, 9'd7);
        exp_q.push_back(rsp_t'{1'b1, 9'd7, 32'h0});
        cyc(); pif.req_i = 1'b0;
        nb(); chk1("pw_fll_req", fif.fll_req_o, 1'b0); chk1("pw_r_valid", pif.r_valid_o, 1'b1);
        cyc();

        // Timeout with no ack
        issue(1'b1, 32'hC, 32'h0, 4'hF, 9'd9);
        exp_q.push_back(rsp_t'{1'b1, 9'd9, 32'h0});
        cyc(); pif.req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            nb(); chk1("tmo_fll_req", fif.fll_req_o, 1'b1);
            cyc();
        end
        nb(); chk1("tmo_fll_req_drop", fif.fll_req_o, 1'b0); chk1("tmo_r_valid", pif.r_valid_o, 1'b1);
        cyc();

        // Ack on the final cycle beats the timeout
        issue(1'b1, 32'hC, 32'h0, 4'hF, 9'd10);
        exp_q.push_back(rsp_t'{1'b0, 9'd10, 32'h0000A5A5});
        cyc(); pif.req_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) begin
                fif.fll_ack_i = 1'b1; fif.fll_r_data_i = 32'h0000A5A5;
            end
            nb(); chk1("late_ack_fll_req", fif.fll_req_o, 1'b1);
            cyc();
        end
        fif.fll_ack_i = 1'b0; fif.fll_r_data_i = '0;
        nb(); chk1("late_ack_r_valid", pif.r_valid_o, 1'b1);
        cyc();

        // Back-to-back partial writes with req held high
        issue(1'b0, 32'h0, 32'h0, 4'h3, 9'd11);
        exp_q.push_back(rsp_t'{1'b1, 9'd11, 32'h0});
        nb(); chk1("b2b_gnt0", pif.gnt_o, 1'b1);
        cyc(); pif.id_i = 9'd12;
        nb(); chk1("b2b_stall", pif.gnt_o, 1'b0);
        cyc();
        exp_q.push_back(rsp_t'{1'b1, 9'd12, 32'h0});
        nb(); chk1("b2b_gnt1", pif.gnt_o, 1'b1);
        cyc(); pif.req_i = 1'b0;
        nb(); chk1("b2b_r_valid", pif.r_valid_o, 1'b1);
        cyc();

        // Reset in the middle of a transaction, request kept high
        issue(1'b1, 32'h8, 32'h0, 4'hF, 9'd13);
        cyc();
        nb(); chk1("mid_fll_req", fif.fll_req_o, 1'b1); chk1("mid_gnt", pif.gnt_o, 1'b0);
        cyc(); rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            nb(); chk1("mid_rst_fll_req", fif.fll_req_o, 1'b0); chk1("mid_rst_gnt", pif.gnt_o, 1'b0);
            cyc();
        end
        rst = 1'b0;
        exp_q.push_back(rsp_t'{1'b0, 9'd13, 32'h00001111});
        nb(); chk1("mid_release_gnt", pif.gnt_o, 1'b1);
        cyc(); pif.req_i = 1'b0; fif.fll_ack_i = 1'b1; fif.fll_r_data_i = 32'h00001111;
        cyc(); fif.fll_ack_i = 1'b0; fif.fll_r_data_i = '0;
        nb(); chk1("mid_after_r_valid", pif.r_valid_o, 1'b1);
        cyc();

        // Lock synchroniser: rise then fall
        fif.fll_lock_i = 1'b1;
        nb(); chk1("lock_rise_0", fif.lock_o, 1'b0);
        cyc();
        nb(); chk1("lock_rise_1", fif.lock_o, 1'b0);
        cyc();
        nb(); chk1("lock_rise_2", fif.lock_o, 1'b1); chk1("lock_lost_idle", fif.lock_lost_o, 1'b0);
        cyc(); fif.fll_lock_i = 1'b0;
        nb(); chk1("lock_fall_0", fif.lock_o, 1'b1);
        cyc();
        nb(); chk1("lock_fall_1", fif.lock_o, 1'b1); chk1("lost_fall_1", fif.lock_lost_o, 1'b0);
        cyc();
        nb(); chk1("lock_fall_2", fif.lock_o, 1'b0); chk1("lost_pulse", fif.lock_lost_o, 1'b1);
        cyc();
        nb(); chk1("lost_single", fif.lock_lost_o, 1'b0);

        // No lock-loss pulse across a reset
        fif.fll_lock_i = 1'b1;
        cyc(); cyc(); cyc();
        nb(); chk1("lock_pre_rst", fif.lock_o, 1'b1);
        cyc(); rst = 1'b1; fif.fll_lock_i = 1'b0;
        cyc(); cyc(); rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nb(); chk1("lost_after_rst", fif.lock_lost_o, 1'b0);
            cyc();
        end

        cyc(); cyc();
        chk("pending_rsp", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
